// File: rtl/pkg_teclado.sv
// ---------------------------------------------------------------------------
// pkg_teclado
//
// Shared definitions for the scanned 4x4 keypad reader.
//   - state_t      : scanner FSM states.
//   - KEY_*        : key codes (row*4 + column) for the game keypad layout.
//   - prio_row()   : picks the winning low row (lowest index wins).
//   - make_code()  : packs a row/column pair into a 4-bit key code.
//
// Physical legend (row 0 at the top, column 0 at the left):
//     1 2 3 A
//     4 5 6 B
//     7 8 9 C
//     * 0 # D
// '#' is used as FIRE and '*' as CLEAR by the coordinate/fire logic.
// ---------------------------------------------------------------------------
package pkg_teclado;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Digit keys mapped to where their legend sits on the pad.
    localparam logic [3:0] KEY_1     = 4'd0;
    localparam logic [3:0] KEY_2     = 4'd1;
    localparam logic [3:0] KEY_3     = 4'd2;
    localparam logic [3:0] KEY_A     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_B     = 4'd7;
    localparam logic [3:0] KEY_7     = 4'd8;
    localparam logic [3:0] KEY_8     = 4'd9;
    localparam logic [3:0] KEY_9     = 4'd10;
    localparam logic [3:0] KEY_C     = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_0     = 4'd13;
    localparam logic [3:0] KEY_FIRE  = 4'd14;
    localparam logic [3:0] KEY_D     = 4'd15;

    // Rows are active-low; when several are low the lowest index wins.
    // Scanning from the top index down lets the lowest index overwrite.
    function automatic logic [1:0] prio_row(input logic [3:0] rows_n);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] make_code(input logic [1:0] row,
                                             input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/modulo_sincronizador.sv
// ---------------------------------------------------------------------------
// modulo_sincronizador
//
// 4-bit two-flop synchronizer for the keypad row lines. Resets to all-ones
// so that the idle (pulled-up) level is seen immediately after reset and no
// phantom press can be detected.
//
// Ports:
//   clk  in   system clock
//   clr  in   asynchronous active-high reset
//   d    in   [3:0] raw rows, asynchronous to clk
//   q    out  [3:0] synchronized rows
// ---------------------------------------------------------------------------
module modulo_sincronizador (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    // One independent two-stage chain per row line.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/modulo_varredura_teclado.sv
// ---------------------------------------------------------------------------
// modulo_varredura_teclado
//
// Scanned 4x4 keypad reader. One column is driven low at a time; the rows
// are sampled once per column dwell (the "tick"), a press is debounced over
// DEBOUNCE_SCANS consecutive matching ticks and reported as a one-cycle
// strobe with a 4-bit key code. The release is debounced the same way.
//
// Parameters:
//   SCAN_DIV        clk cycles per column dwell (>= 4)
//   DEBOUNCE_SCANS  matching ticks needed to accept press/release (1..15)
//
// Ports:
//   clk        in   system clock
//   clr        in   asynchronous active-high reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous
//   col_out    out  [3:0] column drive, active-low one-hot
//   key_valid  out  one-cycle strobe on an accepted press
//   key_code   out  [3:0] row*4 + column of the last accepted key
//   key_held   out  high from the strobe until the release is accepted
// ---------------------------------------------------------------------------
module modulo_varredura_teclado
    import pkg_teclado::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int         DW      = $clog2(SCAN_DIV);
    localparam logic [3:0] DS      = 4'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] rs;

    modulo_sincronizador u_sinc (
        .clk (clk),
        .clr (clr),
        .d   (row_in),
        .q   (rs)
    );

    // ------------------------------------------------------------------
    // Dwell counter: free-running, the last count is the only sample point.
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell_reg;
    logic          tick;

    assign tick = (dwell_reg == DWELL_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dwell_reg <= '0;
        end else if (tick) begin
            dwell_reg <= '0;
        end else begin
            dwell_reg <= dwell_reg + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scanner FSM, column index and output registers
    // ------------------------------------------------------------------
    state_t     state_reg,     state_next;
    logic [1:0] col_reg,       col_next;
    logic [3:0] cnt_reg,       cnt_next;
    logic [1:0] cand_row_reg,  cand_row_next;
    logic [1:0] cand_col_reg,  cand_col_next;
    logic       key_valid_reg, key_valid_next;
    logic [3:0] key_code_reg,  key_code_next;
    logic       key_held_reg,  key_held_next;

    logic       rows_idle;
    logic [1:0] win_row;
    logic [3:0] cnt_inc;

    assign rows_idle = (rs == 4'hF);
    assign win_row   = prio_row(rs);
    // cnt saturates so a long stable period can never wrap back below DS.
    assign cnt_inc   = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        cnt_next       = cnt_reg;
        cand_row_next  = cand_row_reg;
        cand_col_next  = cand_col_reg;
        key_valid_next = 1'b0;
        key_code_next  = key_code_reg;
        key_held_next  = key_held_reg;

        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (!rows_idle) begin
                        cand_row_next = win_row;
                        cand_col_next = col_reg;
                        cnt_next      = 4'd1;
                        if (DS == 4'd1) begin
                            // Single-sample debounce: accept on detection.
                            key_code_next  = make_code(win_row, col_reg);
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            state_next     = HELD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (!rows_idle && (win_row == cand_row_reg)) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= DS) begin
                            key_code_next  = make_code(cand_row_reg, cand_col_reg);
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            state_next     = HELD;
                        end
                    end else begin
                        // Bounce or a different key: rescan the same column.
                        state_next = SCAN;
                    end
                end

                HELD: begin
                    // Only a fully idle row set starts the release; other
                    // rows going low are ignored (no rollover).
                    if (rows_idle) begin
                        cnt_next = 4'd1;
                        if (DS == 4'd1) begin
                            key_held_next = 1'b0;
                            col_next      = col_reg + 2'd1;
                            state_next    = SCAN;
                        end else begin
                            state_next = RELEASE;
                        end
                    end
                end

                RELEASE: begin
                    if (rows_idle) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= DS) begin
                            key_held_next = 1'b0;
                            col_next      = col_reg + 2'd1;
                            state_next    = SCAN;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end

                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            cnt_reg       <= 4'd0;
            cand_row_reg  <= 2'd0;
            cand_col_reg  <= 2'd0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 4'h0;
            key_held_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            cnt_reg       <= cnt_next;
            cand_row_reg  <= cand_row_next;
            cand_col_reg  <= cand_col_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            key_held_reg  <= key_held_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: active-low one-hot column drive decoded from col_reg.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign key_held  = key_held_reg;

endmodule
